// File: rtl/tb_simd_sched_if.sv
// Request, datapath and response bus shared between the decoder engines, the turbo
// SIMD datapath and the round-robin scheduler.
interface tb_simd_sched_if #(
   parameter int NUM_REQ = 4
) ();
   logic [NUM_REQ-1:0]    req_valid_i;
   logic [NUM_REQ-1:0]    req_ready_o;
   logic [3*NUM_REQ-1:0]  req_op_i;
   logic [32*NUM_REQ-1:0] req_a_i;
   logic [32*NUM_REQ-1:0] req_b_i;
   logic                  dp_valid_o;
   logic [2:0]            dp_op_o;
   logic [31:0]           dp_a_o;
   logic [31:0]           dp_b_o;
   logic [31:0]           dp_result_i;
   logic [NUM_REQ-1:0]    rsp_valid_o;
   logic [31:0]           rsp_data_o;
   logic                  rsp_err_o;

   modport slave (
      input  req_valid_i, req_op_i, req_a_i, req_b_i, dp_result_i,
      output req_ready_o, dp_valid_o, dp_op_o, dp_a_o, dp_b_o,
             rsp_valid_o, rsp_data_o, rsp_err_o
   );

   modport master (
      output req_valid_i, req_op_i, req_a_i, req_b_i, dp_result_i,
      input  req_ready_o, dp_valid_o, dp_op_o, dp_a_o, dp_b_o,
             rsp_valid_o, rsp_data_o, rsp_err_o
   );
endinterface

// File: rtl/tb_simd_sched.sv
// Round-robin scheduler sharing one fixed-latency int8x4 SIMD datapath between NUM_REQ
// requesters, with per-requester credits, in-order result routing and a drain mode.
//
//   state     | meaning
//   ST_RUN    | normal operation, grants allowed while drain_i is low
//   ST_DRAIN  | no new grants, waiting for in-flight ops to leave the tag pipeline
//   ST_DONE   | drained, nothing in flight; drained_o high until drain_i drops
module tb_simd_sched #(
   parameter int NUM_REQ = 4,
   parameter int LATENCY = 1,
   parameter int MAX_OUT = 2
) (
   input  logic           clk_i,
   input  logic           rst_i,
   tb_simd_sched_if.slave bus,
   input  logic           drain_i,
   output logic           drained_o,
   output logic           busy_o
);
   localparam int IDW = $clog2(NUM_REQ);
   localparam int IW1 = IDW + 1;
   localparam int CW  = $clog2(MAX_OUT + 1);
   localparam logic [2:0] OP_ILLEGAL = 3'd7;

   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_e;

   state_e             state_q;
   logic               drained_q;
   logic [IDW-1:0]     ptr_q;
   logic [CW-1:0]      cnt_q [NUM_REQ];
   logic               dp_valid_q;
   logic [2:0]         dp_op_q;
   logic [31:0]        dp_a_q;
   logic [31:0]        dp_b_q;
   logic [LATENCY:0]   tag_vld_q;
   logic [LATENCY:0]   tag_err_q;
   logic [IDW-1:0]     tag_id_q [LATENCY+1];
   logic [NUM_REQ-1:0] rsp_valid_q;
   logic [31:0]        rsp_data_q;
   logic               rsp_err_q;

   logic [NUM_REQ-1:0] elig;
   logic [NUM_REQ-1:0] grant;
   logic               gnt_any;
   logic [IDW-1:0]     gnt_id;
   logic [2:0]         gnt_op;
   logic [31:0]        gnt_a;
   logic [31:0]        gnt_b;
   logic [IW1-1:0]     scan_sum;
   logic [IDW-1:0]     scan_idx;
   logic               empty;

   assign empty = ~|tag_vld_q;

   // A credit retiring this cycle may be reused by an accept in the same cycle.
   always_comb begin
      elig = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         elig[i] = bus.req_valid_i[i] & ((cnt_q[i] < CW'(MAX_OUT)) | rsp_valid_q[i])
                   & (state_q == ST_RUN) & ~drain_i & ~rst_i;
      end
   end

   always_comb begin
      gnt_any  = 1'b0;
      gnt_id   = '0;
      scan_sum = '0;
      scan_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_sum = {1'b0, ptr_q} + IW1'(k);
         scan_idx = (scan_sum >= IW1'(NUM_REQ)) ? IDW'(scan_sum - IW1'(NUM_REQ))
                                                : scan_sum[IDW-1:0];
         if (!gnt_any && elig[scan_idx]) begin
            gnt_any = 1'b1;
            gnt_id  = scan_idx;
         end
      end
      grant = '0;
      if (gnt_any) grant[gnt_id] = 1'b1;
      gnt_op = '0;
      gnt_a  = '0;
      gnt_b  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            gnt_op = bus.req_op_i[3*i +: 3];
            gnt_a  = bus.req_a_i[32*i +: 32];
            gnt_b  = bus.req_b_i[32*i +: 32];
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr_q       <= '0;
         dp_valid_q  <= 1'b0;
         dp_op_q     <= '0;
         dp_a_q      <= '0;
         dp_b_q      <= '0;
         tag_vld_q   <= '0;
         tag_err_q   <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         for (int s = 0; s <= LATENCY; s++) tag_id_q[s] <= '0;
         for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
      end else begin
         if (gnt_any) ptr_q <= (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + IDW'(1);

         // Illegal ops skip the datapath but still occupy their tag slot.
         dp_valid_q <= gnt_any && (gnt_op != OP_ILLEGAL);
         if (gnt_any && (gnt_op != OP_ILLEGAL)) begin
            dp_op_q <= gnt_op;
            dp_a_q  <= gnt_a;
            dp_b_q  <= gnt_b;
         end

         tag_vld_q[0] <= gnt_any;
         tag_err_q[0] <= gnt_any && (gnt_op == OP_ILLEGAL);
         tag_id_q[0]  <= gnt_id;
         for (int s = 1; s <= LATENCY; s++) begin
            tag_vld_q[s] <= tag_vld_q[s-1];
            tag_err_q[s] <= tag_err_q[s-1];
            tag_id_q[s]  <= tag_id_q[s-1];
         end

         rsp_valid_q <= '0;
         rsp_err_q   <= 1'b0;
         if (tag_vld_q[LATENCY]) begin
            rsp_valid_q[tag_id_q[LATENCY]] <= 1'b1;
            rsp_data_q <= tag_err_q[LATENCY] ? 32'd0 : bus.dp_result_i;
            rsp_err_q  <= tag_err_q[LATENCY];
         end

         for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i] && !rsp_valid_q[i])      cnt_q[i] <= cnt_q[i] + CW'(1);
            else if (!grant[i] && rsp_valid_q[i]) cnt_q[i] <= cnt_q[i] - CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_RUN;
         drained_q <= 1'b0;
      end else begin
         unique case (state_q)
            ST_RUN: begin
               if (drain_i) begin
                  state_q   <= empty ? ST_DONE : ST_DRAIN;
                  drained_q <= empty;
               end
            end
            ST_DRAIN: begin
               if (!drain_i) begin
                  state_q <= ST_RUN;
               end else if (empty) begin
                  state_q   <= ST_DONE;
                  drained_q <= 1'b1;
               end
            end
            ST_DONE: begin
               if (!drain_i) begin
                  state_q   <= ST_RUN;
                  drained_q <= 1'b0;
               end
            end
            default: begin
               state_q   <= ST_RUN;
               drained_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ready_o = grant;
   assign bus.dp_valid_o  = dp_valid_q;
   assign bus.dp_op_o     = dp_op_q;
   assign bus.dp_a_o      = dp_a_q;
   assign bus.dp_b_o      = dp_b_q;
   assign bus.rsp_valid_o = rsp_valid_q;
   assign bus.rsp_data_o  = rsp_data_q;
   assign bus.rsp_err_o   = rsp_err_q;
   assign busy_o          = (|tag_vld_q) | dp_valid_q;
   assign drained_o       = drained_q;
endmodule
